csr_hpm: RTL

CSR_HPM -- requirements
Module: csr_hpm

---
 rtl/csr_hpm.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/csr_hpm.sv
// csr_hpm: machine-mode counter CSRs (mcycle, minstret, mhpmcounter3..)
// with mcountinhibit, mhpmevent selectors and a few read-only ID registers.
//
// Ports
//   clock_i       sole clock, rising edge
//   reset_i       asynchronous active-high reset
//   wen_i         CSR write strobe
//   op_i          01 RW, 10 RS, 11 RC, 00 no write
//   addr_i        CSR address (read and write)
//   wdata_i       write operand
//   rdata_o       combinational read of addr_i
//   illegal_o     combinational illegal-access flag for the current write
//   is_instret_i  instruction retired this cycle
//   is_ebreak_i   core halted on ebreak this cycle
//   hpm_event_i   per-cycle event pulses
module csr_hpm #(
    parameter int N_HPM = 4,
    parameter int CNT_W = 64,
    parameter int N_EVT = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             wen_i,
    input  logic [1:0]       op_i,
    input  logic [11:0]      addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic             illegal_o,
    input  logic             is_instret_i,
    input  logic             is_ebreak_i,
    input  logic [N_EVT-1:0] hpm_event_i
);
    localparam int N_CNT = N_HPM + 2;
    localparam logic [1:0]  OP_RW     = 2'b01;
    localparam logic [1:0]  OP_RS     = 2'b10;
    localparam logic [1:0]  OP_RC     = 2'b11;
    localparam logic [31:0] MISA      = 32'h4000_0010;
    localparam logic [31:0] MVENDORID = 32'h616B_6562;  // "akeb"
    localparam logic [31:0] MARCHID   = 32'h0531_8008;

    function automatic logic [31:0] inh_mask();
        logic [31:0] m;
        m = 32'h0000_0005;
        for (int i = 3; i < N_HPM + 3; i++) m[i] = 1'b1;
        return m;
    endfunction
    localparam logic [31:0] INH_MASK = inh_mask();

    // Counter slots: 0 = mcycle, 1 = minstret, 2.. = mhpmcounter3..
    // The CSR offset (and mcountinhibit bit) of slot s is 0 for mcycle, s+1 otherwise.
    function automatic logic [11:0] cnt_off(int s);
        return (s == 0) ? 12'd0 : 12'(s + 1);
    endfunction

    logic [CNT_W-1:0] cnt_q [N_CNT];
    logic [CNT_W-1:0] cnt_d [N_CNT];
    logic [31:0]      inh_q, inh_d;
    logic [4:0]       evt_q [N_HPM];
    logic [4:0]       evt_d [N_HPM];

    logic             mapped, read_only, nonzero, wr_go;
    logic [31:0]      wval;
    logic [31:0]      evt_ext;
    logic [N_CNT-1:0] inc;

    always_comb begin
        rdata_o   = '0;
        mapped    = 1'b0;
        read_only = 1'b0;
        case (addr_i)
            12'h301: begin rdata_o = MISA;      mapped = 1'b1; read_only = 1'b1; end
            12'hF11: begin rdata_o = MVENDORID; mapped = 1'b1; read_only = 1'b1; end
            12'hF12: begin rdata_o = MARCHID;   mapped = 1'b1; read_only = 1'b1; end
            12'h320: begin rdata_o = inh_q;     mapped = 1'b1; end
            default: ;
        endcase
        for (int i = 0; i < N_HPM; i++) begin
            if (addr_i == 12'h323 + 12'(i)) begin
                rdata_o = {27'd0, evt_q[i]};
                mapped  = 1'b1;
            end
        end
        for (int s = 0; s < N_CNT; s++) begin
            if (addr_i == 12'hB00 + cnt_off(s)) begin
                rdata_o = cnt_q[s][31:0];
                mapped  = 1'b1;
            end
            if (addr_i == 12'hB80 + cnt_off(s)) begin
                rdata_o = 32'(cnt_q[s][CNT_W-1:32]);
                mapped  = 1'b1;
            end
        end
    end

    // RS/RC with a zero operand is a pure read: it is legal on read-only
    // CSRs and must not disturb a counter (its increment is kept).
    always_comb begin
        nonzero   = (op_i == OP_RW) || (wdata_i != 32'd0);
        illegal_o = wen_i && (op_i != 2'b00) &&
                    (!mapped || (read_only && nonzero) ||
                     (op_i == OP_RW && addr_i[11:10] == 2'b11));
        wr_go     = wen_i && (op_i != 2'b00) && !illegal_o && nonzero && !read_only;
        case (op_i)
            OP_RS:   wval = rdata_o | wdata_i;
            OP_RC:   wval = rdata_o & ~wdata_i;
            default: wval = wdata_i;
        endcase
    end

    // Event index 0 and indices beyond the event bus never count.
    always_comb begin
        evt_ext = 32'(hpm_event_i);
        inc     = '0;
        inc[0]  = !inh_q[0] && !is_ebreak_i;
        inc[1]  = is_instret_i && !inh_q[2];
        for (int i = 0; i < N_HPM; i++) begin
            if (evt_q[i] != 5'd0 && int'(evt_q[i]) < N_EVT)
                inc[i+2] = evt_ext[evt_q[i]] && !inh_q[i+3];
        end
    end

    // A write to either half of a counter replaces the increment; the other
    // half keeps its pre-increment value.
    always_comb begin
        inh_d = inh_q;
        for (int i = 0; i < N_HPM; i++) evt_d[i] = evt_q[i];
        for (int s = 0; s < N_CNT; s++)
            cnt_d[s] = cnt_q[s] + {{(CNT_W-1){1'b0}}, inc[s]};
        if (wr_go) begin
            if (addr_i == 12'h320) inh_d = wval & INH_MASK;
            for (int i = 0; i < N_HPM; i++) begin
                if (addr_i == 12'h323 + 12'(i)) evt_d[i] = wval[4:0];
            end
            for (int s = 0; s < N_CNT; s++) begin
                if (addr_i == 12'hB00 + cnt_off(s))
                    cnt_d[s] = {cnt_q[s][CNT_W-1:32], wval};
                if (addr_i == 12'hB80 + cnt_off(s))
                    cnt_d[s] = {wval[CNT_W-33:0], cnt_q[s][31:0]};
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            inh_q <= '0;
            for (int i = 0; i < N_HPM; i++) evt_q[i] <= '0;
            for (int s = 0; s < N_CNT; s++) cnt_q[s] <= '0;
        end else begin
            inh_q <= inh_d;
            for (int i = 0; i < N_HPM; i++) evt_q[i] <= evt_d[i];
            for (int s = 0; s < N_CNT; s++) cnt_q[s] <= cnt_d[s];
        end
    end

endmodule
